uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parity-checked UART transmitter, the send-side counterpart to the team's UART receiver. It accepts one parallel data word per ready/valid handshake and serialises it as one start bit (0), the data word LSB first, one parity bit and one stop bit (1). Its frame format, parity sense and baud derivation are identical to the receiver's, so `TX` can be looped directly into the receiver in the top-level UART design.

## Interface
- `BAUD_RATE`, 115200: line bit rate.
- `CLK_FREQ`, 10_000_000: `CLK` frequency in Hz. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, integer division, truncated (86 at defaults). `CLKS_PER_BIT >= 2` is required.
- `VLD_DATA_WIDTH`, 8: data bits per frame, 1..16.
- `CHECK_SEL`, 1: parity sense. 1 = odd (parity bit = `~^din_q`); 0 = even (parity bit = `^din_q`).

Ports:
- `CLK`  input  1  clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `din`  input  `VLD_DATA_WIDTH`  word to send. Sampled only on acceptance.
- `din_vld`  input  1  `din` valid.
- `din_rdy`  output  1  high only in IDLE. Acceptance = `din_vld && din_rdy` at a rising edge.
- `TX`  output  1  serial line, registered, idles high.
- `tx_busy`  output  1  high whenever state != IDLE.
- `tx_done`  output  1  one-cycle pulse marking the end of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Transitions:
  - IDLE→START on acceptance.
  - START→DATA, DATA→PARITY and PARITY→STOP each after the bit completes. DATA leaves only after `VLD_DATA_WIDTH` bits.
  - STOP→IDLE after the stop bit.
- A bit completes when the baud counter `clk_cnt` (counting 0..`CLKS_PER_BIT`-1) reaches `CLKS_PER_BIT`-1. `clk_cnt` then wraps to 0. `clk_cnt` is held at 0 in IDLE.
- `bit_cnt` counts data bits 0..`VLD_DATA_WIDTH`-1. It is width-sized to hold `VLD_DATA_WIDTH`-1, cleared on entry to DATA, and incremented at each data-bit completion.
- On acceptance `din` is latched into `din_q`, and the parity bit is computed from `din_q` and registered before PARITY begins. Changes on `din` or `din_vld` while busy are ignored and are not queued.
- `TX` per state: START = 0; DATA = `din_q[bit_cnt]`; PARITY = parity bit; STOP and IDLE = 1.
- `tx_done` asserts in the final cycle of STOP, the cycle whose edge returns the FSM to IDLE.
- Reset, including reset mid-frame: state IDLE, `TX`=1, `din_rdy`=1, `tx_busy`=0, `tx_done`=0, counters 0, `din_q`=0. The frame in progress is abandoned and no partial stop bit is emitted.
- Illegal state encodings recover to IDLE with `TX`=1.

## Timing
- Acceptance edge: `TX` falls at this edge, so the start bit occupies the next `CLKS_PER_BIT` cycles. `din_rdy` drops and `tx_busy` rises at the same edge.
- Each bit, including stop, lasts exactly `CLKS_PER_BIT` cycles.
- Frame length from first start-bit cycle to last stop-bit cycle: `(VLD_DATA_WIDTH+3)*CLKS_PER_BIT` cycles, which is 946 at defaults.
- `din_rdy` is high again the cycle after the `tx_done` cycle.
- Back-to-back transfers with `din_vld` held high give a start-to-start period of `(VLD_DATA_WIDTH+3)*CLKS_PER_BIT + 1` cycles (947 at defaults). The stop level is therefore held for `CLKS_PER_BIT`+1 cycles.
- `TX` has no combinational path from any input.

## Test plan
- Reset, then hold `din_vld`=0 for 2000 cycles. Required: `TX`=1, `din_rdy`=1, `tx_busy`=0, `tx_done` never pulses.
- Defaults, `din`=0xA5 with a one-cycle `din_vld`. Sample `TX` at each bit centre. Required: 0, 1,0,1,0,0,1,0,1, 1 (odd parity, 0xA5 has four ones), 1. `tx_done` pulses exactly 946 cycles after the first low `TX` cycle.
- `CHECK_SEL`=0, `din`=0x01. Required: parity bit 1. Repeat with `din`=0xFF: parity bit 0.
- `din_vld` held high with `din`=0x3C, then 0xC3. Required: two frames, start-to-start 947 cycles, second frame carries 0xC3. Changing `din` mid-frame must not alter the frame in flight.
- Assert `rst_n` low during data bit 4. Required: `TX`=1 immediately (asynchronous). After release, a new 0x55 frame is transmitted cleanly.
- Loopback into the team's UART receiver with matching parameters, random bytes. Required: receiver `dout` equals the sent byte and receiver `error`=0 for every frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, VLD_DATA_WIDTH data bits LSB first, one parity bit, one stop bit.
// Frame format and baud derivation match the team's UART receiver so TX can loop straight into it.
module uart_tx_frame #(
  parameter int unsigned BAUD_RATE      = 115200,
  parameter int unsigned CLK_FREQ       = 10_000_000,
  parameter int unsigned VLD_DATA_WIDTH = 8,
  parameter bit          CHECK_SEL      = 1'b1
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic [VLD_DATA_WIDTH-1:0] din,
  input  logic                      din_vld,
  output logic                      din_rdy,
  output logic                      TX,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = (VLD_DATA_WIDTH > 1) ? $clog2(VLD_DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(VLD_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_clk_cnt;
  logic [BIT_W-1:0]          r_bit_cnt;
  logic [VLD_DATA_WIDTH-1:0] r_din_q;
  logic                      r_parity;
  logic                      r_tx;
  logic                      r_done;

  logic                      w_bit_end;
  logic                      w_accept;
  logic                      w_parity;
  logic [BIT_W-1:0]          w_bit_next;

  assign w_bit_end  = (r_clk_cnt == CNT_LAST);
  assign w_accept   = din_vld && (r_state == S_IDLE);
  assign w_parity   = CHECK_SEL ? ~^r_din_q : ^r_din_q;
  assign w_bit_next = r_bit_cnt + BIT_W'(1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_din_q   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE || w_bit_end)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + CNT_W'(1);

      // TX is loaded one edge ahead of each bit so the line stays purely registered.
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_din_q <= din;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_parity <= w_parity;
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_tx      <= r_din_q[0];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == BIT_LAST) begin
              r_tx    <= r_parity;
              r_state <= S_PARITY;
            end else begin
              r_bit_cnt <= w_bit_next;
              r_tx      <= r_din_q[w_bit_next];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == CNT_PRE)
            r_done <= 1'b1;
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_tx      <= 1'b1;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign TX      = r_tx;
  assign din_rdy = (r_state == S_IDLE);
  assign tx_busy = (r_state != S_IDLE);
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized self-checking bench for uart_tx_frame: an odd-parity DUT at default rates and an
// even-parity DUT at a faster bit rate, each compared cycle-by-cycle with an ideal frame model.
module tb_uart_tx_frame;

  localparam int CM = 10_000_000 / 115200;  // 86 clocks per bit
  localparam int CE = 1_000_000 / 115200;   // 8 clocks per bit

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [7:0] din_m, din_e;
  logic       vld_m, vld_e;
  logic       rdy_m, rdy_e, tx_m, tx_e, busy_m, busy_e, done_m, done_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          g_t0;
  int          g_done_n;
  logic [10:0] g_obs;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_frame #(
    .BAUD_RATE(115200), .CLK_FREQ(10_000_000), .VLD_DATA_WIDTH(8), .CHECK_SEL(1'b1)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .din(din_m), .din_vld(vld_m), .din_rdy(rdy_m),
    .TX(tx_m), .tx_busy(busy_m), .tx_done(done_m)
  );

  uart_tx_frame #(
    .BAUD_RATE(115200), .CLK_FREQ(1_000_000), .VLD_DATA_WIDTH(8), .CHECK_SEL(1'b0)
  ) dut_e (
    .CLK(CLK), .rst_n(rst_n), .din(din_e), .din_vld(vld_e), .din_rdy(rdy_e),
    .TX(tx_e), .tx_busy(busy_e), .tx_done(done_e)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ideal line level for bit slot k of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input bit odd, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return odd ? ~^d : ^d;
    return 1'b1;
  endfunction

  // Receiver view of a centre-sampled frame: framing or parity problem.
  function automatic bit rx_err(input logic [10:0] o, input bit odd);
    logic [7:0] b;
    logic       p;
    b = o[8:1];
    p = odd ? ~^b : ^b;
    return (o[0] != 1'b0) || (o[10] != 1'b1) || (o[9] != p);
  endfunction

  task automatic watch_frame(input bit sel, input logic [7:0] d);
    int   c;
    bit   odd;
    bit   found;
    int   wave_err, done_cnt, flag_err;
    logic tx, rdy, busy, done;
    c = sel ? CE : CM;
    odd = !sel;
    found = 0;
    wave_err = 0; done_cnt = 0; flag_err = 0;
    g_obs = '1; g_t0 = 0; g_done_n = -1;
    for (int w = 0; w < 4000 && !found; w++) begin
      @(negedge CLK);
      tx = sel ? tx_e : tx_m;
      if (tx === 1'b0) found = 1;
    end
    if (!found) begin
      check("start_timeout", 0, 1);
      return;
    end
    g_t0 = cyc;
    for (int n = 0; n < 11 * c; n++) begin
      if (n > 0) @(negedge CLK);
      tx   = sel ? tx_e   : tx_m;
      rdy  = sel ? rdy_e  : rdy_m;
      busy = sel ? busy_e : busy_m;
      done = sel ? done_e : done_m;
      if (tx !== frame_bit(d, odd, n / c)) wave_err++;
      if (n % c == c / 2) g_obs[n / c] = tx;
      if (done === 1'b1) begin
        done_cnt++;
        g_done_n = n;
      end
      if (busy !== 1'b1 || rdy !== 1'b0) flag_err++;
    end
    check("wave", wave_err, 0);
    check("done_count", done_cnt, 1);
    check("done_pos", g_done_n, 11 * c - 1);
    check("busy_rdy", flag_err, 0);
    @(negedge CLK);
    check("rdy_after", sel ? rdy_e : rdy_m, 1);
    check("tx_idle", sel ? tx_e : tx_m, 1);
    check("done_clr", sel ? done_e : done_m, 0);
  endtask

  // One-cycle valid pulse, then random din/din_vld noise while the frame is in flight.
  task automatic send(input bit sel, input logic [7:0] d);
    int c;
    c = sel ? CE : CM;
    @(negedge CLK);
    if (sel) begin din_e = d; vld_e = 1'b1; end
    else     begin din_m = d; vld_m = 1'b1; end
    fork
      watch_frame(sel, d);
      begin
        @(negedge CLK);
        if (sel) vld_e = 1'b0; else vld_m = 1'b0;
        for (int k = 0; k < (11 * c) / 40 - 1; k++) begin
          repeat (37) @(negedge CLK);
          if (sel) begin din_e = 8'($urandom); vld_e = 1'($urandom); end
          else     begin din_m = 8'($urandom); vld_m = 1'($urandom); end
        end
        if (sel) vld_e = 1'b0; else vld_m = 1'b0;
      end
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int          bad;
    int          t1;
    logic [10:0] obs1;
    logic [7:0]  d;

    rst_n = 1'b0;
    din_m = '0; din_e = '0; vld_m = 1'b0; vld_e = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", tx_m, 1);
    check("rst_rdy", rdy_m, 1);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    rst_n = 1'b1;

    bad = 0;
    repeat (2000) begin
      @(negedge CLK);
      if (tx_m !== 1'b1 || rdy_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) bad++;
      if (tx_e !== 1'b1 || rdy_e !== 1'b1 || busy_e !== 1'b0 || done_e !== 1'b0) bad++;
    end
    check("idle_2000", bad, 0);

    send(0, 8'hA5);
    check("a5_bits", g_obs, {1'b1, 1'b1, 8'hA5, 1'b0});
    check("a5_len", g_done_n + 1, 946);

    send(1, 8'h01);
    check("even01_par", g_obs[9], 1);
    check("even01_bits", g_obs, {1'b1, 1'b1, 8'h01, 1'b0});
    send(1, 8'hFF);
    check("evenff_par", g_obs[9], 0);
    check("evenff_bits", g_obs, {1'b1, 1'b0, 8'hFF, 1'b0});

    @(negedge CLK);
    din_m = 8'h3C; vld_m = 1'b1;
    fork
      watch_frame(0, 8'h3C);
      begin repeat (200) @(negedge CLK); din_m = 8'hC3; end
    join
    t1 = g_t0;
    obs1 = g_obs;
    fork
      watch_frame(0, 8'hC3);
      begin repeat (50) @(negedge CLK); vld_m = 1'b0; end
    join
    check("b2b_f1", obs1, {1'b1, 1'b1, 8'h3C, 1'b0});
    check("b2b_f2", g_obs, {1'b1, 1'b1, 8'hC3, 1'b0});
    check("b2b_period", g_t0 - t1, 947);

    @(negedge CLK);
    din_m = 8'hA6; vld_m = 1'b1;
    @(negedge CLK);
    vld_m = 1'b0;
    check("mid_start", tx_m, 0);
    repeat (5 * CM + CM / 2) @(negedge CLK);
    check("mid_d4", tx_m, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx_m, 1);
    check("mid_rst_rdy", rdy_m, 1);
    check("mid_rst_busy", busy_m, 0);
    check("mid_rst_done", done_m, 0);
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    bad = 0;
    repeat (CM * 3) begin
      @(negedge CLK);
      if (tx_m !== 1'b1 || done_m !== 1'b0 || busy_m !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);
    send(0, 8'h55);
    check("post_rst_55", g_obs, {1'b1, 1'b1, 8'h55, 1'b0});

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send(0, d);
      check("rx_dout", g_obs[8:1], d);
      check("rx_error", rx_err(g_obs, 1'b1), 0);
    end
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      send(1, d);
      check("rx_dout_even", g_obs[8:1], d);
      check("rx_error_even", rx_err(g_obs, 1'b0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
